// File: rtl/cpu6_pipereg_hs_pkg.sv
// Shared widths and helpers for the cpu6 handshaked pipeline stage register.
package cpu6_pipereg_hs_pkg;

  localparam int CPU6_XLEN        = 32;
  localparam int CPU6_PIPE_CTRL_W = 16;
  localparam int CPU6_PIPE_CNT_W  = 16;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/cpu6_dffre.sv
// Flop bank with synchronous active-high reset and load enable.
module cpu6_dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/cpu6_pipereg_hs.sv
// Handshaked pipeline stage: main entry plus optional skid entry, flush, and a
// saturating downstream bubble counter.
module cpu6_pipereg_hs
  import cpu6_pipereg_hs_pkg::*;
#(
  parameter int CTRL_W    = CPU6_PIPE_CTRL_W,
  parameter int DATA_W    = CPU6_XLEN,
  parameter int SKID      = 1,
  parameter int ZERO_DATA = 1,
  parameter int CNT_W     = CPU6_PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flash,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int   VC_W = CTRL_W + 1;
  localparam logic ZD   = (ZERO_DATA != 0);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [VC_W-1:0]   w_main_vc, w_main_vc_d, w_skid_vc, w_skid_vc_d;
  logic [DATA_W-1:0] w_main_data, w_main_data_d, w_skid_data, w_skid_data_d;
  logic [CNT_W-1:0]  w_bubble;
  logic w_main_valid, w_skid_valid, w_in_ready;
  logic w_accept, w_pop, w_main_load_in, w_main_from_skid, w_main_clear;
  logic w_skid_load, w_skid_clear;
  logic w_main_vc_en, w_main_data_en, w_skid_vc_en, w_skid_data_en;

  assign w_main_valid = w_main_vc[VC_W-1];
  assign w_skid_valid = w_skid_vc[VC_W-1];

  // With a skid entry, in_ready comes straight from the skid valid flop.
  if (SKID != 0) begin : g_skid
    assign w_in_ready = ~w_skid_valid;
  end else begin : g_noskid
    assign w_in_ready = ~w_main_valid | out_ready;
  end

  assign w_accept         = in_valid & w_in_ready & ~flash;
  assign w_pop            = w_main_valid & out_ready;
  assign w_main_from_skid = w_pop & w_skid_valid;
  assign w_main_load_in   = w_accept & (~w_main_valid | (w_pop & ~w_skid_valid));
  assign w_main_clear     = w_pop & ~w_skid_valid & ~w_accept;
  assign w_skid_load      = w_accept & ~w_main_load_in;
  assign w_skid_clear     = w_main_from_skid;

  // Emptied entries store zero ctrl so out_ctrl is zero whenever out_valid is low.
  always_comb begin
    w_main_vc_d   = '0;
    w_main_data_d = '0;
    w_skid_vc_d   = '0;
    w_skid_data_d = '0;
    if (!flash) begin
      if (w_main_from_skid) begin
        w_main_vc_d   = w_skid_vc;
        w_main_data_d = w_skid_data;
      end else if (w_main_load_in) begin
        w_main_vc_d   = {1'b1, in_ctrl};
        w_main_data_d = in_data;
      end
      if (w_skid_load) w_skid_vc_d = {1'b1, in_ctrl};
      w_skid_data_d = in_data;
    end
  end

  assign w_main_vc_en   = flash | w_main_clear | w_main_load_in | w_main_from_skid;
  assign w_main_data_en = flash ? ZD : (w_main_load_in | w_main_from_skid);
  assign w_skid_vc_en   = flash | w_skid_clear | w_skid_load;
  assign w_skid_data_en = flash ? ZD : w_skid_load;

  cpu6_dffre #(.W(VC_W)) u_main_vc (
    .clk(clk), .reset(reset), .en(w_main_vc_en), .d(w_main_vc_d), .q(w_main_vc)
  );
  cpu6_dffre #(.W(DATA_W)) u_main_data (
    .clk(clk), .reset(reset), .en(w_main_data_en), .d(w_main_data_d), .q(w_main_data)
  );
  cpu6_dffre #(.W(VC_W)) u_skid_vc (
    .clk(clk), .reset(reset), .en(w_skid_vc_en), .d(w_skid_vc_d), .q(w_skid_vc)
  );
  cpu6_dffre #(.W(DATA_W)) u_skid_data (
    .clk(clk), .reset(reset), .en(w_skid_data_en), .d(w_skid_data_d), .q(w_skid_data)
  );
  cpu6_dffre #(.W(CNT_W)) u_bubble (
    .clk(clk), .reset(reset), .en(out_ready & ~w_main_valid), .d(sat_inc(w_bubble)), .q(w_bubble)
  );

  assign in_ready   = w_in_ready;
  assign out_valid  = w_main_valid;
  assign out_ctrl   = w_main_vc[CTRL_W-1:0];
  assign out_data   = w_main_data;
  assign occupancy  = occ_count(w_main_valid, w_skid_valid);
  assign bubble_cnt = w_bubble;

endmodule

// File: tb/tb_cpu6_pipereg_hs.sv
// Three configurations of the stage register driven in lockstep against a FIFO reference model.
module tb_cpu6_pipereg_hs;

  logic        clk = 1'b0;
  logic        reset, flash, in_valid, out_ready;
  logic [15:0] in_ctrl;
  logic [31:0] in_data;

  logic        ir [3];
  logic        ov [3];
  logic [15:0] oc [3];
  logic [31:0] od [3];
  logic [1:0]  occ [3];
  logic [15:0] bc0, bc1;
  logic [2:0]  bc2;

  int n_chk = 0;
  int n_err = 0;

  // reference model: up to two queued entries per instance, head at index 0
  logic [15:0] mq_c [3][2];
  logic [31:0] mq_d [3][2];
  int          mn   [3];
  int          mb   [3];
  logic [31:0] mdo  [3];

  always #5 clk = ~clk;

  cpu6_pipereg_hs #(.CTRL_W(16), .DATA_W(32), .SKID(1), .ZERO_DATA(1), .CNT_W(16)) u0 (
    .clk(clk), .reset(reset), .flash(flash), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc[0]), .out_data(od[0]), .occupancy(occ[0]), .bubble_cnt(bc0)
  );
  cpu6_pipereg_hs #(.CTRL_W(16), .DATA_W(32), .SKID(0), .ZERO_DATA(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .flash(flash), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc[1]), .out_data(od[1]), .occupancy(occ[1]), .bubble_cnt(bc1)
  );
  cpu6_pipereg_hs #(.CTRL_W(16), .DATA_W(32), .SKID(1), .ZERO_DATA(0), .CNT_W(3)) u2 (
    .clk(clk), .reset(reset), .flash(flash), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc[2]), .out_data(od[2]), .occupancy(occ[2]), .bubble_cnt(bc2)
  );

  function automatic int skid_of(int k);
    return (k == 1) ? 0 : 1;
  endfunction

  function automatic bit zd_of(int k);
    return (k == 2) ? 1'b0 : 1'b1;
  endfunction

  function automatic int bmax_of(int k);
    return (k == 2) ? 7 : 65535;
  endfunction

  function automatic logic [15:0] bubble_of(int k);
    if (k == 0) return bc0;
    if (k == 1) return bc1;
    return {13'b0, bc2};
  endfunction

  function automatic bit m_in_ready(int k);
    return (mn[k] < 1 + skid_of(k)) || (skid_of(k) == 0 && out_ready);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("u%0d.in_ready", k), 64'(ir[k]), 64'(m_in_ready(k)));
      check($sformatf("u%0d.out_valid", k), 64'(ov[k]), 64'(mn[k] > 0));
      check($sformatf("u%0d.out_ctrl", k), 64'(oc[k]), (mn[k] > 0) ? 64'(mq_c[k][0]) : 64'd0);
      check($sformatf("u%0d.out_data", k), 64'(od[k]), 64'(mdo[k]));
      check($sformatf("u%0d.occupancy", k), 64'(occ[k]), 64'(mn[k]));
      check($sformatf("u%0d.bubble_cnt", k), 64'(bubble_of(k)), 64'(mb[k]));
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      bit rdy = m_in_ready(k);
      bit vld = (mn[k] > 0);
      if (reset) begin
        mn[k]  = 0;
        mb[k]  = 0;
        mdo[k] = '0;
      end else begin
        if (out_ready && !vld && mb[k] < bmax_of(k)) mb[k]++;
        if (flash) begin
          mn[k] = 0;
          if (zd_of(k)) mdo[k] = '0;
        end else begin
          if (vld && out_ready) begin
            mq_c[k][0] = mq_c[k][1];
            mq_d[k][0] = mq_d[k][1];
            mn[k]--;
          end
          if (in_valid && rdy) begin
            mq_c[k][mn[k]] = in_ctrl;
            mq_d[k][mn[k]] = in_data;
            mn[k]++;
          end
        end
        if (mn[k] > 0) mdo[k] = mq_d[k][0];
      end
    end
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic rdy, input logic fl);
    in_valid  = v;
    in_ctrl   = c;
    in_data   = {c, ~c};
    out_ready = rdy;
    flash     = fl;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      mn[k]  = 0;
      mb[k]  = 0;
      mdo[k] = '0;
    end
    reset = 1'b1;
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst.u%0d.out_valid", k), 64'(ov[k]), 64'd0);
      check($sformatf("rst.u%0d.out_ctrl", k), 64'(oc[k]), 64'd0);
      check($sformatf("rst.u%0d.occupancy", k), 64'(occ[k]), 64'd0);
      check($sformatf("rst.u%0d.bubble_cnt", k), 64'(bubble_of(k)), 64'd0);
      check($sformatf("rst.u%0d.in_ready", k), 64'(ir[k]), 64'd1);
    end
    reset = 1'b0;

    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 16'(i), 1'b1, 1'b0);
      step();
      check("stream.ctrl", 64'(oc[0]), 64'(i));
      check("stream.occ", 64'(occ[0]), 64'd1);
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();

    drive(1'b1, 16'h00AA, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h00BB, 1'b0, 1'b0);
    step();
    check("bp.occ", 64'(occ[0]), 64'd2);
    check("bp.in_ready", 64'(ir[0]), 64'd0);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    check("bp.headA", 64'(oc[0]), 64'h00AA);
    step();
    check("bp.headB", 64'(oc[0]), 64'h00BB);
    check("bp.ready_after_pop", 64'(ir[0]), 64'd1);
    step();
    check("bp.drained", 64'(ov[0]), 64'd0);

    drive(1'b1, 16'h0011, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0022, 1'b0, 1'b0);
    step();
    check("fl.occ_before", 64'(occ[2]), 64'd2);
    drive(1'b1, 16'h0033, 1'b0, 1'b1);
    step();
    check("fl.out_valid", 64'(ov[0]), 64'd0);
    check("fl.out_ctrl", 64'(oc[0]), 64'd0);
    check("fl.occ", 64'(occ[0]), 64'd0);
    check("fl.zero_data", 64'(od[0]), 64'd0);
    check("fl.keep_data", 64'(od[2]), 64'h0011FFEE);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    step();

    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();
    check("bub.five", 64'(bc0), 64'd5);
    repeat (5) step();
    check("bub.sat", 64'(bc2), 64'd7);
    drive(1'b0, 16'h0, 1'b1, 1'b1);
    step();
    check("bub.flash_keeps", 64'(bc2), 64'd7);
    check("bub.flash_count", 64'(bc0), 64'd11);

    drive(1'b1, 16'h0044, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0055, 1'b0, 1'b0);
    step();
    check("s0.in_ready", 64'(ir[1]), 64'd0);
    check("s0.hold", 64'(oc[1]), 64'h0044);
    drive(1'b1, 16'h0066, 1'b1, 1'b0);
    step();
    check("s0.replace", 64'(oc[1]), 64'h0066);
    check("s0.occ", 64'(occ[1]), 64'd1);

    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 19) == 0);
      step();
    end
    reset = 1'b0;
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
